// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one Avalon-MM master port between the instruction-fetch path
//   (read-only) and the data load/store path. Round-robin on ties, one access
//   in flight at a time, IDLE -> BUS -> ACK per access.
//
// Parameters
//   WAIT_TIMEOUT  max cycles read/write may sit under waitrequest before the
//                 access is abandoned with err; 0 disables the timeout.
//
// Ports
//   clk, reset                       clock, synchronous active-high reset
//   i_req, i_addr                    fetch request (held until i_ack)
//   i_ack, i_rdata                   fetch done pulse, registered fetch word
//   d_req, d_write, d_addr,
//   d_wdata, d_byteenable            data request (held until d_ack)
//   d_ack, d_rdata                   data done pulse, registered load word
//   err                              pulses with the ack of a timed-out access
//   address, read, write, writedata,
//   byteenable, waitrequest, readdata   Avalon-MM master
module mem_bus_arbiter #(
  parameter int WAIT_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_byteenable,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        err,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  // Counter only has to reach WAIT_TIMEOUT-1: the abandon happens on the edge
  // that would take it to WAIT_TIMEOUT.
  localparam int            CW        = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'((WAIT_TIMEOUT > 0) ? WAIT_TIMEOUT - 1 : 0);

  logic [1:0]    state;
  logic          last_d;    // 1 = data port won the previous grant
  logic          gnt_d;     // 1 = data port owns the access in flight
  logic          pick_d;
  logic          timeout_hit;
  logic [CW-1:0] wait_cnt;
  logic [31:0]   sel_addr;

  // Data wins when it is alone, or on a tie when fetch went last.
  always_comb begin
    pick_d      = d_req && (!i_req || !last_d);
    sel_addr    = pick_d ? d_addr : i_addr;
    timeout_hit = (WAIT_TIMEOUT > 0) && waitrequest && (wait_cnt == WAIT_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      last_d     <= 1'b1;
      gnt_d      <= 1'b0;
      wait_cnt   <= '0;
      address    <= '0;
      writedata  <= '0;
      byteenable <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
      err        <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      // Acks and err live exactly for the ACK cycle.
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_req || d_req) begin
            gnt_d    <= pick_d;
            last_d   <= pick_d;
            wait_cnt <= '0;
            address  <= sel_addr & 32'hFFFF_FFFC;
            if (pick_d) begin
              byteenable <= d_byteenable;
              read       <= !d_write;
              write      <= d_write;
              if (d_write) writedata <= d_wdata;
            end else begin
              byteenable <= 4'hF;
              read       <= 1'b1;
              write      <= 1'b0;
            end
            state <= S_BUS;
          end
        end
        S_BUS: begin
          if (!waitrequest) begin
            if (read) begin
              if (gnt_d) d_rdata <= readdata;
              else       i_rdata <= readdata;
            end
            read  <= 1'b0;
            write <= 1'b0;
            i_ack <= !gnt_d;
            d_ack <= gnt_d;
            state <= S_ACK;
          end else if (timeout_hit) begin
            // Abandon: ack the requester so it is not stuck, flag err, keep rdata.
            read  <= 1'b0;
            write <= 1'b0;
            i_ack <= !gnt_d;
            d_ack <= gnt_d;
            err   <= 1'b1;
            state <= S_ACK;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_ACK:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_write, waitrequest;
  logic [31:0] i_addr, d_addr, d_wdata, readdata;
  logic [3:0]  d_byteenable;

  logic        i_ack, d_ack, err, read, write;
  logic [31:0] i_rdata, d_rdata, address, writedata;
  logic [3:0]  byteenable;

  logic        nt_i_ack, nt_d_ack, nt_err, nt_read, nt_write;
  logic [31:0] nt_i_rdata, nt_d_rdata, nt_address, nt_writedata;
  logic [3:0]  nt_byteenable;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.WAIT_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata), .d_byteenable(d_byteenable),
    .d_ack(d_ack), .d_rdata(d_rdata), .err(err), .address(address), .read(read), .write(write),
    .waitrequest(waitrequest), .writedata(writedata), .byteenable(byteenable), .readdata(readdata));

  // Same stimulus, timeout disabled.
  mem_bus_arbiter #(.WAIT_TIMEOUT(0)) dut_nt (
    .clk(clk), .reset(reset), .i_req(i_req), .i_addr(i_addr), .i_ack(nt_i_ack), .i_rdata(nt_i_rdata),
    .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata), .d_byteenable(d_byteenable),
    .d_ack(nt_d_ack), .d_rdata(nt_d_rdata), .err(nt_err), .address(nt_address), .read(nt_read),
    .write(nt_write), .waitrequest(waitrequest), .writedata(nt_writedata), .byteenable(nt_byteenable),
    .readdata(readdata));

  // Observations of one access on dut (collected here, judged by the callers).
  int          ob_bus_n, ob_first_k, ob_ack_k;
  logic        ob_iack, ob_dack, ob_err, ob_unstable, ob_both;
  logic        ob_rd, ob_wr;
  logic [31:0] ob_addr, ob_wd;
  logic [3:0]  ob_be;

  // Called at the negedge of the cycle in which the request is sampled (k=0).
  // Plays an Avalon slave that stalls w cycles then accepts with rd.
  // Returns at the negedge of the ack cycle, before any input changes.
  task automatic txn(input int w, input logic [31:0] rd);
    ob_bus_n = 0; ob_first_k = 0; ob_ack_k = 0; ob_unstable = 0; ob_both = 0;
    ob_iack = 0; ob_dack = 0; ob_err = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if ((read && write) || (i_ack && d_ack)) ob_both = 1;
      if (read || write) begin
        if (ob_bus_n == 0) begin
          ob_first_k = k; ob_addr = address; ob_rd = read; ob_wr = write;
          ob_be = byteenable; ob_wd = writedata;
        end else if ({address, read, write, byteenable, writedata} !== {ob_addr, ob_rd, ob_wr, ob_be, ob_wd})
          ob_unstable = 1;
        waitrequest = (ob_bus_n < w);
        readdata    = waitrequest ? $urandom : rd;
        ob_bus_n++;
      end else begin
        waitrequest = 1'b1;
        readdata    = $urandom;
      end
      if (i_ack || d_ack || err) begin
        if (ob_bus_n > 0 && {address, byteenable, writedata} !== {ob_addr, ob_be, ob_wd}) ob_unstable = 1;
        ob_ack_k = k; ob_iack = i_ack; ob_dack = d_ack; ob_err = err;
        return;
      end
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; i_req = 0; d_req = 0; d_write = 0; i_addr = 0; d_addr = 0; d_wdata = 0;
    d_byteenable = 0; waitrequest = 1; readdata = 0;
    repeat (2) @(negedge clk);
    n_chk++; if (address !== 32'h0) $display("FAIL reset_address got %h want 0", address); else n_pass++;
    n_chk++; if ({writedata, byteenable} !== 36'h0) $display("FAIL reset_wd_be got %h/%h want 0", writedata, byteenable); else n_pass++;
    n_chk++; if ({read, write} !== 2'b00) $display("FAIL reset_rw got %b want 00", {read, write}); else n_pass++;
    n_chk++; if ({i_ack, d_ack, err} !== 3'b000) $display("FAIL reset_ack got %b want 000", {i_ack, d_ack, err}); else n_pass++;
    n_chk++; if ({i_rdata, d_rdata} !== 64'h0) $display("FAIL reset_rdata got %h/%h want 0", i_rdata, d_rdata); else n_pass++;
    n_chk++; if ({nt_read, nt_write, nt_address} !== 34'h0) $display("FAIL reset_nt got %b%b %h want 0", nt_read, nt_write, nt_address); else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_single_fetch();
    i_req = 1; i_addr = 32'hBFC0_0000;
    txn(0, 32'h2402_0005);
    i_req = 0;
    n_chk++; if (ob_first_k !== 1 || ob_bus_n !== 1) $display("FAIL fetch_read_window got start %0d len %0d want 1 1", ob_first_k, ob_bus_n); else n_pass++;
    n_chk++; if ({ob_addr, ob_rd, ob_wr, ob_be} !== {32'hBFC0_0000, 1'b1, 1'b0, 4'hF}) $display("FAIL fetch_bus got %h %b%b %b", ob_addr, ob_rd, ob_wr, ob_be); else n_pass++;
    n_chk++; if (ob_ack_k !== 2 || {ob_iack, ob_dack, ob_err} !== 3'b100) $display("FAIL fetch_ack got cyc %0d %b want 2 100", ob_ack_k, {ob_iack, ob_dack, ob_err}); else n_pass++;
    n_chk++; if (i_rdata !== 32'h2402_0005 || d_rdata !== 32'h0) $display("FAIL fetch_rdata got %h/%h want 24020005/0", i_rdata, d_rdata); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_data_load();
    d_req = 1; d_write = 0; d_addr = 32'h0000_1003; d_byteenable = 4'b1100; d_wdata = 32'h5555_AAAA;
    txn(3, 32'hDEAD_BEEF);
    d_req = 0;
    n_chk++; if (ob_first_k !== 1 || ob_bus_n !== 4) $display("FAIL load_read_window got start %0d len %0d want 1 4", ob_first_k, ob_bus_n); else n_pass++;
    n_chk++; if ({ob_addr, ob_rd, ob_wr, ob_be} !== {32'h0000_1000, 1'b1, 1'b0, 4'b1100}) $display("FAIL load_bus got %h %b%b %b", ob_addr, ob_rd, ob_wr, ob_be); else n_pass++;
    n_chk++; if (ob_unstable !== 0) $display("FAIL load_stable got unstable=%b want 0", ob_unstable); else n_pass++;
    n_chk++; if (ob_ack_k !== 5 || {ob_iack, ob_dack, ob_err} !== 3'b010) $display("FAIL load_ack got cyc %0d %b want 5 010", ob_ack_k, {ob_iack, ob_dack, ob_err}); else n_pass++;
    n_chk++; if (d_rdata !== 32'hDEAD_BEEF || i_rdata !== 32'h2402_0005) $display("FAIL load_rdata got %h/%h", d_rdata, i_rdata); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_store();
    d_req = 1; d_write = 1; d_addr = 32'h0000_2002; d_wdata = 32'h1234_5678; d_byteenable = 4'b0011;
    txn(1, 32'hCAFE_F00D);
    d_req = 0;
    n_chk++; if ({ob_rd, ob_wr, ob_wd, ob_be} !== {1'b0, 1'b1, 32'h1234_5678, 4'b0011}) $display("FAIL store_bus got %b%b %h %b", ob_rd, ob_wr, ob_wd, ob_be); else n_pass++;
    n_chk++; if (ob_addr !== 32'h0000_2000 || ob_bus_n !== 2 || ob_unstable !== 0) $display("FAIL store_window got %h len %0d unst %b", ob_addr, ob_bus_n, ob_unstable); else n_pass++;
    n_chk++; if (ob_ack_k !== 3 || {ob_iack, ob_dack, ob_err} !== 3'b010) $display("FAIL store_ack got cyc %0d %b want 3 010", ob_ack_k, {ob_iack, ob_dack, ob_err}); else n_pass++;
    n_chk++; if (d_rdata !== 32'hDEAD_BEEF) $display("FAIL store_rdata got %h want deadbeef", d_rdata); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    pulse_reset();
    i_req = 1; i_addr = 32'h0000_0100; d_req = 1; d_write = 0; d_addr = 32'h0000_0200; d_byteenable = 4'hF;
    for (int t = 0; t < 4; t++) begin
      txn(t % 2, 32'hA0 + t);
      n_chk++;
      if ({ob_iack, ob_dack} !== ((t % 2 == 0) ? 2'b10 : 2'b01) || ob_both !== 0 || ob_ack_k !== (t % 2) + 2)
        $display("FAIL b2b_grant%0d got ack %b%b both %b cyc %0d", t, ob_iack, ob_dack, ob_both, ob_ack_k);
      else n_pass++;
      if (t == 3) begin i_req = 0; d_req = 0; end
      @(negedge clk);
    end
    n_chk++; if (i_rdata !== 32'hA2 || d_rdata !== 32'hA3) $display("FAIL b2b_rdata got %h/%h want a2/a3", i_rdata, d_rdata); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic bad;
    i_req = 1; i_addr = 32'h0000_0300; waitrequest = 1;
    @(negedge clk);
    n_chk++; if (read !== 1'b1) $display("FAIL midrst_started got read %b want 1", read); else n_pass++;
    @(negedge clk);
    reset = 1; i_req = 0;
    @(negedge clk);
    n_chk++; if ({read, write, nt_read, address, i_rdata, d_rdata, i_ack} !== 100'h0) $display("FAIL midrst_outputs got rw %b%b nt %b addr %h rdata %h/%h", read, write, nt_read, address, i_rdata, d_rdata); else n_pass++;
    reset = 0; bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (i_ack || d_ack || err || read || write) bad = 1;
    end
    n_chk++; if (bad !== 0) $display("FAIL midrst_quiet got activity=%b want 0", bad); else n_pass++;
    i_req = 1; i_addr = 32'h0000_0400;
    txn(0, 32'h1111_2222);
    i_req = 0;
    n_chk++; if (ob_ack_k !== 2 || !ob_iack || ob_err || i_rdata !== 32'h1111_2222) $display("FAIL midrst_fresh got cyc %0d ack %b err %b rdata %h", ob_ack_k, ob_iack, ob_err, i_rdata); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    logic bad;
    i_req = 1; i_addr = 32'h0000_0500;
    txn(100, 32'h0000_0099);
    i_req = 0; waitrequest = 1;
    n_chk++; if (ob_bus_n !== 4 || ob_ack_k !== 5) $display("FAIL timeout_window got len %0d ack cyc %0d want 4 5", ob_bus_n, ob_ack_k); else n_pass++;
    n_chk++; if ({ob_iack, ob_dack, ob_err} !== 3'b101) $display("FAIL timeout_ack_err got %b want 101", {ob_iack, ob_dack, ob_err}); else n_pass++;
    n_chk++; if (i_rdata !== 32'h1111_2222) $display("FAIL timeout_rdata got %h want 11112222", i_rdata); else n_pass++;
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (nt_read !== 1'b1 || nt_i_ack || nt_err || read) bad = 1;
    end
    n_chk++; if (bad !== 0) $display("FAIL notimeout_hold got bad=%b want 0", bad); else n_pass++;
    waitrequest = 0; readdata = 32'h0000_0077;
    @(negedge clk);
    waitrequest = 1;
    n_chk++; if ({nt_read, nt_i_ack, nt_err} !== 3'b010 || nt_i_rdata !== 32'h77) $display("FAIL notimeout_accept got %b rdata %h", {nt_read, nt_i_ack, nt_err}, nt_i_rdata); else n_pass++;
    @(negedge clk);
  endtask

  // Reference: transaction-level round robin with a "data went last" flag.
  task automatic test_random();
    logic        m_last_d, exp_d, exp_rd, exp_wr;
    logic [31:0] m_ir, m_dr, exp_addr, rd;
    logic [3:0]  exp_be;
    int          w;
    pulse_reset();
    m_last_d = 1; m_ir = 0; m_dr = 0; i_req = 0; d_req = 0;
    for (int it = 0; it < 40; it++) begin
      if (!i_req && $urandom_range(0, 2) != 0) begin i_req = 1; i_addr = $urandom; end
      if (!d_req && $urandom_range(0, 2) != 0) begin
        d_req = 1; d_addr = $urandom; d_write = 1'($urandom_range(0, 1)); d_wdata = $urandom; d_byteenable = 4'($urandom);
      end
      if (!i_req && !d_req) begin i_req = 1; i_addr = $urandom; end
      exp_d    = (i_req && d_req) ? !m_last_d : d_req;
      exp_addr = (exp_d ? d_addr : i_addr) & 32'hFFFF_FFFC;
      exp_rd   = exp_d ? !d_write : 1'b1;
      exp_wr   = exp_d && d_write;
      exp_be   = exp_d ? d_byteenable : 4'hF;
      w = $urandom_range(0, 3); rd = $urandom;
      txn(w, rd);
      if (exp_rd) begin if (exp_d) m_dr = rd; else m_ir = rd; end
      m_last_d = exp_d;
      n_chk++; if (ob_first_k !== 1 || ob_bus_n !== w + 1 || ob_ack_k !== w + 2) $display("FAIL rnd%0d_timing got %0d/%0d/%0d w=%0d", it, ob_first_k, ob_bus_n, ob_ack_k, w); else n_pass++;
      n_chk++; if ({ob_addr, ob_rd, ob_wr, ob_be} !== {exp_addr, exp_rd, exp_wr, exp_be}) $display("FAIL rnd%0d_bus got %h %b%b %b want %h %b%b %b", it, ob_addr, ob_rd, ob_wr, ob_be, exp_addr, exp_rd, exp_wr, exp_be); else n_pass++;
      if (exp_wr) begin
        n_chk++; if (ob_wd !== d_wdata) $display("FAIL rnd%0d_wdata got %h want %h", it, ob_wd, d_wdata); else n_pass++;
      end
      n_chk++; if ({ob_iack, ob_dack, ob_err, ob_both, ob_unstable} !== {!exp_d, exp_d, 3'b000}) $display("FAIL rnd%0d_ack got %b%b err %b both %b unst %b", it, ob_iack, ob_dack, ob_err, ob_both, ob_unstable); else n_pass++;
      n_chk++; if ({i_rdata, d_rdata} !== {m_ir, m_dr}) $display("FAIL rnd%0d_rdata got %h/%h want %h/%h", it, i_rdata, d_rdata, m_ir, m_dr); else n_pass++;
      n_chk++; if ({nt_i_rdata, nt_d_rdata} !== {m_ir, m_dr}) $display("FAIL rnd%0d_nt_rdata got %h/%h want %h/%h", it, nt_i_rdata, nt_d_rdata, m_ir, m_dr); else n_pass++;
      // Winner either drops or presents a fresh request in its ack cycle.
      if (exp_d) begin
        d_req = 1'($urandom_range(0, 1));
        if (d_req) begin d_addr = $urandom; d_write = 1'($urandom_range(0, 1)); d_wdata = $urandom; d_byteenable = 4'($urandom); end
      end else begin
        i_req = 1'($urandom_range(0, 1));
        if (i_req) i_addr = $urandom;
      end
      @(negedge clk);
    end
    i_req = 0; d_req = 0;
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_data_load();
    test_store();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
